// File: rtl/axilite_txn_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axilite_txn_scheduler_pkg                                                |
// | Shared NoC/AXI-lite encodings: scheduler/response FSM states, type codes |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axilite_txn_scheduler_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_DATA = 2'd1,
        RSP_DONE = 2'd2
    } rsp_state_e;

    localparam logic [1:0] c_msg_type_load  = 2'd1;
    localparam logic [1:0] c_msg_type_store = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axilite_txn_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axilite_txn_scheduler                                                    |
// | Round-robin read/write grant scheduler with outstanding-count and fence  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axilite_txn_scheduler
    import axilite_txn_scheduler_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 16,
    parameter int         ADDR_WIDTH      = 64,
    parameter logic [1:0] MSG_TYPE_LOAD   = c_msg_type_load,
    parameter logic [1:0] MSG_TYPE_STORE  = c_msg_type_store
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req_valid,
    input  logic [ADDR_WIDTH-1:0]              rd_req_addr,
    output logic                               rd_req_ready,
    input  logic                               wr_req_valid,
    input  logic [ADDR_WIDTH-1:0]              wr_req_addr,
    output logic                               wr_req_ready,
    output logic                               grant_valid,
    output logic                               grant_is_store,
    output logic [ADDR_WIDTH-1:0]              grant_addr,
    input  logic                               grant_ready,
    output logic                               transaction_type_wr,
    output logic [2:0]                         transaction_type_wr_data,
    input  logic                               rsp_done,
    input  logic                               fence,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_underflow
);

    localparam int                 c_cnt_w   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    sched_state_e              r_state;
    sched_state_e              w_next_state;
    logic                      r_last_store;
    logic                      r_grant_is_store;
    logic [ADDR_WIDTH-1:0]     r_grant_addr;
    logic [c_cnt_w-1:0]        r_outstanding;
    logic                      r_err_underflow;
    logic                      w_can_grant;
    logic                      w_any_valid;
    logic                      w_pick_store;
    logic                      w_accept;
    logic                      w_handshake;

    assign w_any_valid  = rd_req_valid | wr_req_valid;
    assign w_can_grant  = (r_outstanding < c_cnt_max) && !(fence && (r_outstanding != '0));
    // Write wins only when read is absent or read was the last channel granted.
    assign w_pick_store = wr_req_valid && (!rd_req_valid || !r_last_store);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        grant_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid && w_can_grant) begin
                    w_accept     = 1'b1;
                    w_next_state = GRANT;
                    wr_req_ready = w_pick_store;
                    rd_req_ready = !w_pick_store;
                end
            end
            GRANT: begin
                grant_valid = 1'b1;
                if (grant_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_last_store     <= 1'b1;
            r_grant_is_store <= 1'b0;
            r_grant_addr     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_last_store     <= w_pick_store;
                r_grant_is_store <= w_pick_store;
                r_grant_addr     <= w_pick_store ? wr_req_addr : rd_req_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding   <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_handshake && !rsp_done) begin
                r_outstanding <= r_outstanding + c_cnt_one;
            end else if (rsp_done && !w_handshake) begin
                if (r_outstanding == '0) begin
                    r_err_underflow <= 1'b1;
                end else begin
                    r_outstanding <= r_outstanding - c_cnt_one;
                end
            end
        end
    end

    assign grant_is_store           = r_grant_is_store;
    assign grant_addr               = r_grant_addr;
    assign transaction_type_wr      = w_handshake;
    assign transaction_type_wr_data = {(r_grant_is_store ? MSG_TYPE_STORE : MSG_TYPE_LOAD),
                                       r_grant_addr[3]};
    assign outstanding              = r_outstanding;
    assign err_underflow            = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_axilite_txn_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axilite_txn_scheduler                                                 |
// | Directed self-checking bench for axilite_txn_scheduler                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axilite_txn_scheduler;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic          rd_req_ready;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic          wr_req_ready;
    logic          grant_valid;
    logic          grant_is_store;
    logic [AW-1:0] grant_addr;
    logic          grant_ready;
    logic          transaction_type_wr;
    logic [2:0]    transaction_type_wr_data;
    logic          rsp_done;
    logic          fence;
    logic [4:0]    outstanding;
    logic          err_underflow;

    int checks = 0;
    int errors = 0;

    axilite_txn_scheduler #(
        .MAX_OUTSTANDING(16),
        .ADDR_WIDTH     (AW),
        .MSG_TYPE_LOAD  (2'd1),
        .MSG_TYPE_STORE (2'd2)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .rd_req_valid             (rd_req_valid),
        .rd_req_addr              (rd_req_addr),
        .rd_req_ready             (rd_req_ready),
        .wr_req_valid             (wr_req_valid),
        .wr_req_addr              (wr_req_addr),
        .wr_req_ready             (wr_req_ready),
        .grant_valid              (grant_valid),
        .grant_is_store           (grant_is_store),
        .grant_addr               (grant_addr),
        .grant_ready              (grant_ready),
        .transaction_type_wr      (transaction_type_wr),
        .transaction_type_wr_data (transaction_type_wr_data),
        .rsp_done                 (rsp_done),
        .fence                    (fence),
        .outstanding              (outstanding),
        .err_underflow            (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        grant_ready  = 1'b0;
        rsp_done     = 1'b0;
        fence        = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic grant_read(input logic [AW-1:0] addr);
        rd_req_valid = 1'b1;
        rd_req_addr  = addr;
        grant_ready  = 1'b1;
        tick();
        rd_req_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        wr_req_valid = 1'b0;
        wr_req_addr  = '0;
        grant_ready  = 1'b0;
        rsp_done     = 1'b0;
        fence        = 1'b0;
        #3;
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_type_wr", transaction_type_wr, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_grant_addr", grant_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single read at 0x1008
        rd_req_valid = 1'b1;
        rd_req_addr  = 64'h1008;
        grant_ready  = 1'b1;
        #1;
        chk("single_rd_ready", rd_req_ready, 1);
        chk("single_wr_ready", wr_req_ready, 0);
        chk("single_no_grant_yet", grant_valid, 0);
        tick();
        rd_req_valid = 1'b0;
        #1;
        chk("single_grant_valid", grant_valid, 1);
        chk("single_is_store", grant_is_store, 0);
        chk("single_grant_addr", grant_addr, 64'h1008);
        chk("single_type_wr", transaction_type_wr, 1);
        chk("single_type_data", transaction_type_wr_data, 3'b011);
        chk("single_out_before", outstanding, 0);
        tick();
        chk("single_out_after", outstanding, 1);
        chk("single_grant_drop", grant_valid, 0);
        chk("single_type_wr_drop", transaction_type_wr, 0);

        // Round robin, read first after reset
        do_reset();
        rd_req_valid = 1'b1;
        rd_req_addr  = 64'h100;
        wr_req_valid = 1'b1;
        wr_req_addr  = 64'h208;
        grant_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rd_ready", rd_req_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_wr_ready", wr_req_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_is_store", grant_is_store, (k % 2 == 1) ? 1 : 0);
            chk("rr_type_data", transaction_type_wr_data, (k % 2 == 1) ? 3'b101 : 3'b010);
            chk("rr_type_wr", transaction_type_wr, 1);
            tick();
        end
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
        chk("rr_outstanding", outstanding, 4);

        // Handshake coincident with rsp_done at outstanding 5
        grant_read(64'h0);
        chk("coinc_pre", outstanding, 5);
        rd_req_valid = 1'b1;
        rd_req_addr  = 64'h18;
        tick();
        rd_req_valid = 1'b0;
        rsp_done     = 1'b1;
        #1;
        chk("coinc_type_wr", transaction_type_wr, 1);
        chk("coinc_type_data", transaction_type_wr_data, 3'b011);
        tick();
        rsp_done = 1'b0;
        #1;
        chk("coinc_out", outstanding, 5);
        chk("coinc_single_push", transaction_type_wr, 0);

        // Saturate at MAX_OUTSTANDING
        do_reset();
        for (int i = 0; i < 16; i++) grant_read(64'h40 + 64'(i * 8));
        chk("full_out", outstanding, 16);
        rd_req_valid = 1'b1;
        wr_req_valid = 1'b1;
        wr_req_addr  = 64'h3000;
        #1;
        chk("full_rd_ready", rd_req_ready, 0);
        chk("full_wr_ready", wr_req_ready, 0);
        tick();
        chk("full_hold_grant", grant_valid, 0);
        chk("full_hold_out", outstanding, 16);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        chk("full_after_rsp", outstanding, 15);
        chk("full_wr_wins", wr_req_ready, 1);
        chk("full_rd_loses", rd_req_ready, 0);
        tick();
        chk("full_grant_store", grant_is_store, 1);
        chk("full_grant_addr", grant_addr, 64'h3000);
        tick();
        chk("full_refilled", outstanding, 16);
        chk("full_rd_ready2", rd_req_ready, 0);
        chk("full_wr_ready2", wr_req_ready, 0);
        tick();
        chk("full_no_extra", grant_valid, 0);
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;

        // Fence with two outstanding
        do_reset();
        grant_read(64'h10);
        grant_read(64'h20);
        chk("fence_pre", outstanding, 2);
        fence        = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 64'h2000;
        grant_ready  = 1'b0;
        #1;
        chk("fence_blocked", rd_req_ready, 0);
        tick();
        chk("fence_no_grant", grant_valid, 0);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        chk("fence_out1", outstanding, 1);
        chk("fence_still_blocked", rd_req_ready, 0);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        chk("fence_out0", outstanding, 0);
        chk("fence_released", rd_req_ready, 1);
        tick();
        rd_req_valid = 1'b0;
        chk("fence_grant", grant_valid, 1);
        chk("fence_grant_addr", grant_addr, 64'h2000);
        tick();
        chk("stall_grant_held", grant_valid, 1);
        chk("stall_addr_held", grant_addr, 64'h2000);
        chk("stall_no_push", transaction_type_wr, 0);
        grant_ready = 1'b1;
        #1;
        chk("stall_push", transaction_type_wr, 1);
        chk("stall_type_data", transaction_type_wr_data, 3'b010);
        tick();
        fence = 1'b0;
        chk("fence_out_after", outstanding, 1);

        // Underflow, then reset mid-grant
        do_reset();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        #1;
        chk("uf_err", err_underflow, 1);
        chk("uf_out", outstanding, 0);
        tick();
        tick();
        chk("uf_err_sticky", err_underflow, 1);
        rd_req_valid = 1'b1;
        rd_req_addr  = 64'h8;
        grant_ready  = 1'b0;
        tick();
        rd_req_valid = 1'b0;
        chk("mid_grant_valid", grant_valid, 1);
        #2;
        rst         = 1'b1;
        grant_ready = 1'b1;
        #1;
        chk("mid_rst_grant_valid", grant_valid, 0);
        chk("mid_rst_type_wr", transaction_type_wr, 0);
        chk("mid_rst_rd_ready", rd_req_ready, 0);
        chk("mid_rst_wr_ready", wr_req_ready, 0);
        chk("mid_rst_err", err_underflow, 0);
        chk("mid_rst_out", outstanding, 0);
        chk("mid_rst_addr", grant_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_out", outstanding, 0);
        chk("post_rst_grant", grant_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
